// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed 4-digit hex 7-segment scanner with frame-aligned double buffering
module seg_scan_driver #(
    parameter int SCAN_DIV  = 4096,
    parameter int BLANK_CYC = 16,
    parameter int LZ_BLANK  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_in,
    input  logic        data_valid,
    output logic        data_ready,
    output logic [6:0]  seg,
    output logic [3:0]  digit_en,
    output logic        frame_done
);
    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   disp;
    logic [15:0]   shadow;
    logic          pending;
    logic          slot_end;
    logic          frame_wrap;
    logic          accept;
    logic          blank_win;
    logic          lz_off;
    logic [3:0]    nib;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'h7E;
            4'h1: hex7 = 7'h30;
            4'h2: hex7 = 7'h6D;
            4'h3: hex7 = 7'h79;
            4'h4: hex7 = 7'h33;
            4'h5: hex7 = 7'h5B;
            4'h6: hex7 = 7'h5F;
            4'h7: hex7 = 7'h70;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h7B;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h1F;
            4'hC: hex7 = 7'h4E;
            4'hD: hex7 = 7'h3D;
            4'hE: hex7 = 7'h4F;
            default: hex7 = 7'h47;
        endcase
    endfunction

    assign slot_end   = cnt == CW'(SCAN_DIV - 1);
    assign frame_wrap = slot_end && idx == 2'd3;
    assign accept     = data_valid && !pending;
    assign data_ready = !pending;
    assign blank_win  = cnt < CW'(BLANK_CYC);
    assign nib        = disp[{idx, 2'b00} +: 4];

    // digit k>0 goes dark when it and every more-significant nibble are zero
    always_comb begin
        lz_off = 1'b0;
        if (LZ_BLANK == 1)
            lz_off = idx == 2'd1 ? disp[15:4] == 12'h000 :
                     idx == 2'd2 ? disp[15:8] == 8'h00 :
                     idx == 2'd3 ? disp[15:12] == 4'h0 : 1'b0;
    end

    // prescaler and digit index; frame_done marks the cycle after digit 3's slot ends
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= 2'd0;
            frame_done <= 1'b0;
        end else begin
            cnt        <= slot_end ? '0 : cnt + 1'b1;
            idx        <= slot_end ? idx + 2'd1 : idx;
            frame_done <= frame_wrap;
        end
    end

    // shadow takes new data only when empty; display swaps only at a frame boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow  <= 16'h0000;
            disp    <= 16'h0000;
            pending <= 1'b0;
        end else if (accept) begin
            shadow  <= data_in;
            pending <= 1'b1;
        end else if (frame_wrap && pending) begin
            disp    <= shadow;
            pending <= 1'b0;
        end
    end

    // registered drive: dark during the guard interval at the start of each slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg      <= 7'h00;
            digit_en <= 4'b0000;
        end else begin
            seg      <= blank_win || lz_off ? 7'h00 : hex7(nib);
            digit_en <= blank_win ? 4'b0000 : 4'b0001 << idx;
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: table-driven and scoreboard check of seg_scan_driver at SCAN_DIV=8, BLANK_CYC=2
module tb_seg_scan_driver;
    localparam int SD = 8;
    localparam int BC = 2;
    localparam int FR = 4 * SD;

    typedef struct packed {
        logic [15:0] value;
        logic [27:0] segs;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data_in = 16'h0000;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic [6:0]  seg;
    logic [3:0]  digit_en;
    logic        frame_done;

    seg_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC), .LZ_BLANK(1)) dut (
        .clk(clk),
        .rst(rst),
        .data_in(data_in),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .seg(seg),
        .digit_en(digit_en),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    int          t = 0;
    logic        pend = 1'b0;
    logic        accepted = 1'b0;
    logic [27:0] sh = '0;
    logic [27:0] disp_s = '0;
    logic [27:0] cur_segs = '0;
    logic [12:0] sb[$];
    vec_t        vecs[8];

    task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0d got={seg,en,fd,rdy}=%h required=%h", name, t, got, exp);
        end
    endtask

    // reference: cycle count since release gives slot and phase; segment patterns come from the table
    task automatic model_step();
        int         cnt;
        int         idx;
        logic       fw;
        logic [6:0] es;
        logic [3:0] ee;
        cnt = t % SD;
        idx = (t / SD) % 4;
        fw  = cnt == SD - 1 && idx == 3;
        es  = cnt < BC ? 7'h00 : disp_s[idx*7 +: 7];
        ee  = cnt < BC ? 4'b0000 : 4'b0001 << idx;
        accepted = data_valid && !pend;
        if (accepted) begin
            sh   = cur_segs;
            pend = 1'b1;
        end else if (fw && pend) begin
            disp_s = sh;
            pend   = 1'b0;
        end
        sb.push_back({es, ee, fw, !pend});
        t++;
    endtask

    task automatic step();
        logic [12:0] exp;
        model_step();
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard_empty t=%0d", t);
        end else begin
            exp = sb.pop_front();
            check("cycle", {seg, digit_en, frame_done, data_ready}, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("async_reset", {seg, digit_en, frame_done, data_ready}, {7'h00, 4'b0000, 1'b0, 1'b1});
        repeat (2) begin
            @(posedge clk);
            #1;
            check("reset_hold", {seg, digit_en, frame_done, data_ready}, {7'h00, 4'b0000, 1'b0, 1'b1});
        end
        t      = 0;
        pend   = 1'b0;
        disp_s = {7'h00, 7'h00, 7'h00, 7'h7E};
        sb.delete();
        rst = 1'b0;
    endtask

    task automatic run_to(input int phase);
        for (int i = 0; i < 2 * FR && t % FR != phase; i++) step();
    endtask

    task automatic offer(input vec_t v);
        data_in    = v.value;
        cur_segs   = v.segs;
        data_valid = 1'b1;
        for (int i = 0; i < 3 * FR; i++) begin
            step();
            if (accepted) break;
        end
        if (!accepted) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout value=%h", v.value);
        end
        data_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t beef;
        vecs[0] = '{16'h12AF, {7'h30, 7'h6D, 7'h77, 7'h47}};
        vecs[1] = '{16'h0050, {7'h00, 7'h00, 7'h5B, 7'h7E}};
        vecs[2] = '{16'h0000, {7'h00, 7'h00, 7'h00, 7'h7E}};
        vecs[3] = '{16'h8000, {7'h7F, 7'h7E, 7'h7E, 7'h7E}};
        vecs[4] = '{16'h0300, {7'h00, 7'h79, 7'h7E, 7'h7E}};
        vecs[5] = '{16'hC4D6, {7'h4E, 7'h33, 7'h3D, 7'h5F}};
        vecs[6] = '{16'h0E79, {7'h00, 7'h4F, 7'h70, 7'h7B}};
        vecs[7] = '{16'h1234, {7'h30, 7'h6D, 7'h79, 7'h33}};
        beef    = '{16'hBEEF, {7'h1F, 7'h4F, 7'h4F, 7'h47}};

        do_reset();
        repeat (FR + 1) step();

        for (int i = 0; i < 7; i++) begin
            run_to(10);
            offer(vecs[i]);
            repeat (2 * FR + 6) step();
        end

        // busy shadow: BEEF is held off until the swap frees the shadow
        run_to(5);
        offer(vecs[7]);
        data_in    = beef.value;
        cur_segs   = beef.segs;
        data_valid = 1'b1;
        for (int i = 0; i < 3 * FR; i++) begin
            step();
            if (accepted) break;
        end
        check("beef_accept_phase", 13'(t % FR), 13'd1);
        data_valid = 1'b0;
        repeat (2 * FR + 6) step();

        // accept on the very edge of a frame wrap: shown one frame later
        run_to(FR - 1);
        data_in    = 16'h5BF1;
        cur_segs   = {7'h5B, 7'h1F, 7'h47, 7'h30};
        data_valid = 1'b1;
        step();
        check("wrap_edge_ready", {12'h000, data_ready}, 13'd0);
        data_valid = 1'b0;
        repeat (2 * FR + 6) step();

        // reset in digit 2's slot with a value pending: it must never appear
        run_to(2);
        offer(vecs[5]);
        run_to(20);
        do_reset();
        repeat (2 * FR + 6) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL provide parameter SCAN_DIV, default 4096, meaning the clk cycles per digit slot (range 4..65536).
REQ-002 SHALL provide parameter BLANK_CYC, default 16, meaning the clk cycles at the start of each slot with all digits off (anti-ghosting); it must be less than SCAN_DIV.
REQ-003 SHALL provide parameter LZ_BLANK, default 1, meaning leading-zero blanking is enabled when the value is 1.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port data_in, input, 16 bits: four hex digits; nibble [3:0] is digit 0, the rightmost.
REQ-007 SHALL have port data_valid, input, 1 bit: data_in is offered.
REQ-008 SHALL have port data_ready, output, 1 bit: the shadow register is empty and can accept a value.
REQ-009 SHALL have port seg, output, 7 bits: segments active-high; bit 6 = A down to bit 0 = G.
REQ-010 SHALL have port digit_en, output, 4 bits: digit enables, one-hot or zero, active-high; bit 0 = digit 0.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle pulse when digit 3's slot ends.

Function
REQ-012 SHALL keep a prescaler cnt counting 0..SCAN_DIV-1 and wrapping to 0; slot_end is true when cnt == SCAN_DIV-1.
REQ-013 SHALL advance the 2-bit digit index idx 0->1->2->3->0 on each clock edge where slot_end is true.
REQ-014 SHALL define frame_wrap as slot_end && idx == 3, and SHALL register frame_done high for exactly the one cycle after frame_wrap.
REQ-015 SHALL accept data_in into the shadow register and set pending on each edge where data_valid && data_ready is true.
REQ-016 SHALL drive data_ready = !pending, directly from the register.
REQ-017 SHALL, on frame_wrap while pending, copy shadow to the display register disp and clear pending, so no frame ever mixes two values.
REQ-018 SHALL, if an accept and frame_wrap occur on the same edge while pending was 0, store the new value in shadow only; it transfers at the next frame_wrap.
REQ-019 SHALL, if data_valid is high while pending is 1, leave shadow unchanged; the upstream holds data_in until data_ready is high.
REQ-020 SHALL decode hex to seg with this table: 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47.
REQ-021 SHALL, when LZ_BLANK=1, blank digit k>0 (seg=00) if nibbles k..3 of disp are all zero; digit 0 is never blanked.
REQ-022 SHALL register seg and digit_en, each reflecting the cnt/idx/disp state of the previous cycle (latency 1).
REQ-023 SHALL drive digit_en = 0000 and seg = 00 when the previous-cycle cnt < BLANK_CYC.
REQ-024 SHALL otherwise drive digit_en = 1<<idx and seg = decode(disp nibble idx), or 00 if that digit is blanked.

Reset
REQ-025 SHALL, on rst assertion and asynchronously, clear cnt, idx, disp, shadow and pending, and drive seg=00, digit_en=0000, frame_done=0, data_ready=1.
REQ-026 SHALL, on rst mid-frame, discard any pending value; the first post-reset slot is digit 0 with cnt starting at 0.
REQ-027 SHALL release from reset synchronously to clk, with no output glitch on release.

Verification (SCAN_DIV=8, BLANK_CYC=2)
REQ-028 SHALL cover: reset, then 32 cycles idle -> digit_en visits 0001,0010,0100,1000 for 6 cycles each, separated by 2 cycles of 0000; seg=7E only during the 0001 slots; one frame_done pulse after cycle 32.
REQ-029 SHALL cover: accept 0x12AF mid-frame -> data_ready=0 until the frame wraps; the next frame shows seg 47, 77, 6D, 30 on digits 0..3; data_ready=1 the cycle after the wrap.
REQ-030 SHALL cover: LZ_BLANK=1 with value 0x0050 -> digit 0=7E, digit 1=5B, digits 2 and 3 seg=00 with their enables still pulsing.
REQ-031 SHALL cover: second data_valid with 0xBEEF while pending holds 0x1234 -> 0xBEEF is not accepted; after the wrap 0x1234 is displayed and 0xBEEF is accepted the cycle after data_ready rises.
REQ-032 SHALL cover: accept on the same edge as frame_wrap (pending=0) -> value shown only from the following frame.
REQ-033 SHALL cover: rst pulse during the digit 2 slot with pending set -> outputs take their reset values immediately; the pending value is never displayed.
